nlfsr_dispatcher: RTL and testbench

Drives a bank of `nlfsr_tester` instances from one clock domain. It sweeps a contiguous range of feedback-function settings and starts each on a free tester. It collects the settings of testers reporting `success` (maximal period) into a result FIFO with a valid/ready output. It sits between the host search-range interface and the tester array, and is the sole driver of every tester's `start`, `setting_rd_en` and `setting_in`.

---
 rtl/nlfsr_dispatcher.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_nlfsr_dispatcher.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nlfsr_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : nlfsr_dispatcher
//  Purpose  : Sweeps a contiguous range of NLFSR feedback settings across a
//             bank of nlfsr_tester instances. Each setting is started on a
//             free tester. The settings of testers that report a maximal
//             period are collected into a show-ahead result FIFO with a
//             valid/ready output.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst              : clock, synchronous active-high reset
//    cfg_start             : job start pulse (accepted in IDLE / DONE only)
//    first_setting         : first setting of the range (sampled on cfg_start)
//    last_setting          : last setting of the range, inclusive
//    tester_start          : one-hot start pulse per tester (registered)
//    tester_rd_en          : setting read / success-clear pulse per tester
//    tester_setting        : shared setting bus, valid with tester_start
//    tester_idle           : tester idle flags
//    tester_success        : tester success flags
//    tester_setting_out    : packed tester setting outputs, tester k at
//                            [k*SETTING_WIDTH +: SETTING_WIDTH]
//    res_valid/res_data    : result FIFO head (show-ahead)
//    res_ready             : pops the FIFO head when res_valid is high
//    busy, done            : job status
//    dispatched_count      : saturating count of starts issued this job
//    found_count           : saturating count of results written this job
// ============================================================================
module nlfsr_dispatcher #(
  parameter int SHIFTREG_WIDTH = 10,
  parameter int NUM_NLIN       = 1,
  parameter int NUM_NLIN_IDX   = 2,
  parameter int SETTING_WIDTH  = SHIFTREG_WIDTH - 1
                                 + NUM_NLIN * NUM_NLIN_IDX * $clog2(SHIFTREG_WIDTH - 1),
  parameter int NUM_TESTERS    = 4,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cfg_start,
  input  logic [SETTING_WIDTH-1:0]             first_setting,
  input  logic [SETTING_WIDTH-1:0]             last_setting,
  output logic [NUM_TESTERS-1:0]               tester_start,
  output logic [NUM_TESTERS-1:0]               tester_rd_en,
  output logic [SETTING_WIDTH-1:0]             tester_setting,
  input  logic [NUM_TESTERS-1:0]               tester_idle,
  input  logic [NUM_TESTERS-1:0]               tester_success,
  input  logic [NUM_TESTERS*SETTING_WIDTH-1:0] tester_setting_out,
  output logic                                 res_valid,
  output logic [SETTING_WIDTH-1:0]             res_data,
  input  logic                                 res_ready,
  output logic                                 busy,
  output logic                                 done,
  output logic [31:0]                          dispatched_count,
  output logic [31:0]                          found_count
);

  localparam int c_IDX_W = (NUM_TESTERS > 1) ? $clog2(NUM_TESTERS) : 1;
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [c_PTR_W:0]         c_PTR_ONE = (c_PTR_W + 1)'(1);
  localparam logic [SETTING_WIDTH-1:0] c_SET_ONE = SETTING_WIDTH'(1);

  localparam logic [2:0] c_ST_IDLE     = 3'd0;
  localparam logic [2:0] c_ST_FLUSH    = 3'd1;
  localparam logic [2:0] c_ST_DISPATCH = 3'd2;
  localparam logic [2:0] c_ST_DRAIN    = 3'd3;
  localparam logic [2:0] c_ST_DONE     = 3'd4;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0]               r_state;
  logic [SETTING_WIDTH-1:0] r_cursor;
  logic [SETTING_WIDTH-1:0] r_last;
  logic                     r_exhausted;
  logic                     r_idle_seen;
  // Two-stage mask: r_mask_a covers the cycle after a decision, r_mask_b the
  // one after that, which bridges the latency until the tester's idle/success
  // flags reflect the start or rd_en pulse.
  logic [NUM_TESTERS-1:0]   r_mask_a;
  logic [NUM_TESTERS-1:0]   r_mask_b;
  logic [NUM_TESTERS-1:0]   r_start;
  logic [NUM_TESTERS-1:0]   r_rd_en;
  logic [SETTING_WIDTH-1:0] r_setting;
  logic [31:0]              r_disp_cnt;
  logic [31:0]              r_found_cnt;
  logic [c_PTR_W:0]         r_wr_ptr;
  logic [c_PTR_W:0]         r_rd_ptr;
  logic [SETTING_WIDTH-1:0] r_mem [FIFO_DEPTH];

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic [SETTING_WIDTH-1:0] w_slice [NUM_TESTERS];
  logic [NUM_TESTERS-1:0]   w_masked;
  logic                     w_all_idle;
  logic [NUM_TESTERS-1:0]   w_disp_cand;
  logic [NUM_TESTERS-1:0]   w_disp_sel;
  logic                     w_disp_go;
  logic [NUM_TESTERS-1:0]   w_disp_hit;
  logic [NUM_TESTERS-1:0]   w_coll_cand;
  logic [NUM_TESTERS-1:0]   w_coll_sel;
  logic [c_IDX_W-1:0]       w_coll_idx;
  logic                     w_coll_go;
  logic [NUM_TESTERS-1:0]   w_coll_hit;
  logic                     w_fifo_full;
  logic                     w_fifo_empty;
  logic                     w_pop;
  logic                     w_collecting_state;

  for (genvar k = 0; k < NUM_TESTERS; k++) begin : g_slice
    assign w_slice[k] = tester_setting_out[k*SETTING_WIDTH +: SETTING_WIDTH];
  end

  assign w_masked    = r_mask_a | r_mask_b;
  assign w_all_idle  = &tester_idle;

  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
  assign w_fifo_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                        (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
  assign w_pop        = !w_fifo_empty && res_ready;

  // Dispatch: lowest-index idle, unmasked tester.
  assign w_disp_cand = tester_idle & ~w_masked;

  always_comb begin
    w_disp_sel = '0;
    for (int i = NUM_TESTERS - 1; i >= 0; i--) begin
      if (w_disp_cand[i]) begin
        w_disp_sel    = '0;
        w_disp_sel[i] = 1'b1;
      end
    end
  end

  assign w_disp_go  = (r_state == c_ST_DISPATCH) && !r_exhausted && (|w_disp_cand);
  assign w_disp_hit = w_disp_go ? w_disp_sel : '0;

  // Collection: lowest-index successful, unmasked tester. The dispatch target
  // is excluded so both decisions always land on different testers.
  assign w_collecting_state = (r_state == c_ST_DISPATCH) || (r_state == c_ST_DRAIN);
  assign w_coll_cand        = tester_success & ~w_masked & ~w_disp_hit;

  always_comb begin
    w_coll_sel = '0;
    w_coll_idx = '0;
    for (int i = NUM_TESTERS - 1; i >= 0; i--) begin
      if (w_coll_cand[i]) begin
        w_coll_sel    = '0;
        w_coll_sel[i] = 1'b1;
        w_coll_idx    = c_IDX_W'(i);
      end
    end
  end

  // A full FIFO refuses the write even when a pop happens in the same cycle;
  // the tester keeps its success flag and is retried later.
  assign w_coll_go  = w_collecting_state && !w_fifo_full && (|w_coll_cand);
  assign w_coll_hit = w_coll_go ? w_coll_sel : '0;

  // --------------------------------------------------------------------------
  // Control state machine, dispatch and collection
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_ST_IDLE;
      r_cursor    <= '0;
      r_last      <= '0;
      r_exhausted <= 1'b0;
      r_idle_seen <= 1'b0;
      r_mask_a    <= '0;
      r_mask_b    <= '0;
      r_start     <= '0;
      r_rd_en     <= '0;
      r_setting   <= '0;
      r_disp_cnt  <= '0;
      r_found_cnt <= '0;
    end else begin
      r_start  <= '0;
      r_rd_en  <= '0;
      r_mask_b <= r_mask_a;
      r_mask_a <= w_disp_hit | w_coll_hit;

      case (r_state)
        c_ST_IDLE, c_ST_DONE: begin
          if (cfg_start) begin
            r_state     <= c_ST_FLUSH;
            r_cursor    <= first_setting;
            r_last      <= last_setting;
            r_exhausted <= (last_setting < first_setting);
            r_idle_seen <= 1'b0;
            r_disp_cnt  <= '0;
            r_found_cnt <= '0;
          end
        end
        c_ST_FLUSH: begin
          // Clear leftover success flags from an earlier (possibly aborted)
          // job; these reads never reach the FIFO.
          r_rd_en     <= tester_success;
          r_idle_seen <= w_all_idle;
          if (r_idle_seen && w_all_idle) begin
            r_state <= c_ST_DISPATCH;
          end
        end
        c_ST_DISPATCH: begin
          if (r_exhausted) begin
            r_state <= c_ST_DRAIN;
          end
        end
        c_ST_DRAIN: begin
          if (w_all_idle && (w_masked == '0)) begin
            r_state <= c_ST_DONE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase

      if (w_disp_go) begin
        r_start   <= w_disp_sel;
        r_setting <= r_cursor;
        if (r_disp_cnt != '1) begin
          r_disp_cnt <= r_disp_cnt + 32'd1;
        end
        // The exhausted flag ends the range, so an all-ones last setting
        // never wraps the cursor back into a second sweep.
        if (r_cursor == r_last) begin
          r_exhausted <= 1'b1;
        end else begin
          r_cursor <= r_cursor + c_SET_ONE;
        end
      end

      if (w_coll_go) begin
        r_rd_en <= w_coll_sel;
        if (r_found_cnt != '1) begin
          r_found_cnt <= r_found_cnt + 32'd1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Result FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_coll_go) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_coll_go) begin
      r_mem[r_wr_ptr[c_PTR_W-1:0]] <= w_slice[w_coll_idx];
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign tester_start     = r_start;
  assign tester_rd_en     = r_rd_en;
  assign tester_setting   = r_setting;
  assign res_valid        = !w_fifo_empty;
  assign res_data         = r_mem[r_rd_ptr[c_PTR_W-1:0]];
  assign busy             = (r_state == c_ST_FLUSH) || (r_state == c_ST_DISPATCH) ||
                            (r_state == c_ST_DRAIN);
  assign done             = (r_state == c_ST_DONE);
  assign dispatched_count = r_disp_cnt;
  assign found_count      = r_found_cnt;

endmodule
`default_nettype wire

// File: tb/tb_nlfsr_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nlfsr_dispatcher
//  Purpose  : Directed self-checking bench for nlfsr_dispatcher with four
//             behavioural testers (20-cycle run, success on even settings or
//             on every setting) and a two-entry result FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nlfsr_dispatcher;

  localparam int NT = 4;
  localparam int SW = 17;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_start = 1'b0;
  logic [SW-1:0]     first_setting = '0;
  logic [SW-1:0]     last_setting = '0;
  logic [NT-1:0]     tester_start;
  logic [NT-1:0]     tester_rd_en;
  logic [SW-1:0]     tester_setting;
  logic [NT-1:0]     tester_idle;
  logic [NT-1:0]     tester_success;
  logic [NT*SW-1:0]  tester_setting_out;
  logic              res_valid;
  logic [SW-1:0]     res_data;
  logic              res_ready = 1'b0;
  logic              busy;
  logic              done;
  logic [31:0]       dispatched_count;
  logic [31:0]       found_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  nlfsr_dispatcher #(
    .SHIFTREG_WIDTH (10),
    .NUM_NLIN       (1),
    .NUM_NLIN_IDX   (2),
    .SETTING_WIDTH  (SW),
    .NUM_TESTERS    (NT),
    .FIFO_DEPTH     (2)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .cfg_start          (cfg_start),
    .first_setting      (first_setting),
    .last_setting       (last_setting),
    .tester_start       (tester_start),
    .tester_rd_en       (tester_rd_en),
    .tester_setting     (tester_setting),
    .tester_idle        (tester_idle),
    .tester_success     (tester_success),
    .tester_setting_out (tester_setting_out),
    .res_valid          (res_valid),
    .res_data           (res_data),
    .res_ready          (res_ready),
    .busy               (busy),
    .done               (done),
    .dispatched_count   (dispatched_count),
    .found_count        (found_count)
  );

  // ---------------- behavioural testers (no reset, like the real ones) -----
  logic [NT-1:0] t_run  = '0;
  logic [NT-1:0] t_succ = '0;
  int            t_cnt [NT];
  logic [SW-1:0] t_set [NT];
  logic          all_pass = 1'b0;
  logic          preset_req = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < NT; k++) begin
      if (tester_rd_en[k]) t_succ[k] <= 1'b0;
      if (preset_req) begin
        t_run[k]  <= 1'b0;
        t_succ[k] <= 1'b1;
        t_set[k]  <= SW'(32'h3A);
      end else if (tester_start[k]) begin
        t_run[k]  <= 1'b1;
        t_cnt[k]  <= 19;
        t_set[k]  <= tester_setting;
        t_succ[k] <= 1'b0;
      end else if (t_run[k]) begin
        if (t_cnt[k] == 0) begin
          t_run[k]  <= 1'b0;
          t_succ[k] <= all_pass || (t_set[k][0] == 1'b0);
        end else begin
          t_cnt[k] <= t_cnt[k] - 1;
        end
      end
    end
  end

  assign tester_idle    = ~t_run & ~t_succ;
  assign tester_success = t_succ;

  always_comb begin
    tester_setting_out = '0;
    for (int k = 0; k < NT; k++) tester_setting_out[k*SW +: SW] = t_set[k];
  end

  // ---------------- monitor --------------------------------------------------
  int            start_total = 0;
  int            rd_total = 0;
  int            onehot_viol = 0;
  int            rd_per [NT];
  logic [SW-1:0] start_log [$];
  logic [SW-1:0] res_log [$];

  always @(posedge clk) begin
    if (tester_start != '0) begin
      start_total <= start_total + 1;
      start_log.push_back(tester_setting);
    end
    if ($countones(tester_start) > 1) onehot_viol <= onehot_viol + 1;
    if (tester_rd_en != '0) rd_total <= rd_total + 1;
    for (int k = 0; k < NT; k++) if (tester_rd_en[k]) rd_per[k] <= rd_per[k] + 1;
    if (res_valid && res_ready) res_log.push_back(res_data);
  end

  // ---------------- helpers --------------------------------------------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [SW-1:0] f, input logic [SW-1:0] l);
    first_setting = f;
    last_setting  = l;
    cfg_start     = 1'b1;
    @(negedge clk);
    cfg_start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(done), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------------------------------
  initial begin
    int            b_s, b_r, b_rd, cnt;
    int            b_rdp [NT];
    logic [7:0]    m;
    logic [SW-1:0] tmp;
    logic [SW-1:0] ones;
    ones = '1;

    // Reset held for 3 cycles
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_start",   64'(tester_start), 64'd0);
    check("rst_rd_en",   64'(tester_rd_en), 64'd0);
    check("rst_setting", 64'(tester_setting), 64'd0);
    check("rst_valid",   64'(res_valid), 64'd0);
    check("rst_busy",    64'(busy), 64'd0);
    check("rst_done",    64'(done), 64'd0);
    check("rst_disp",    64'(dispatched_count), 64'd0);
    check("rst_found",   64'(found_count), 64'd0);
    repeat (20) @(negedge clk);
    check("idle_no_start", 64'(start_total), 64'd0);
    check("idle_no_rd",    64'(rd_total), 64'd0);

    // Basic range 5..12, even settings succeed
    all_pass  = 1'b0;
    res_ready = 1'b1;
    b_s = start_log.size(); b_r = res_log.size(); b_rd = rd_total;
    start_job(SW'(5), SW'(12));
    check("basic_busy", 64'(busy), 64'd1);
    wait_done("basic_done", 800);
    check("basic_disp",   64'(dispatched_count), 64'd8);
    check("basic_found",  64'(found_count), 64'd4);
    check("basic_nstart", 64'(start_log.size() - b_s), 64'd8);
    for (int i = 0; i < 8; i++)
      if (b_s + i < start_log.size()) check("basic_start_set", 64'(start_log[b_s+i]), 64'(5 + i));
    check("basic_nres", 64'(res_log.size() - b_r), 64'd4);
    for (int i = 0; i < 4; i++)
      if (b_r + i < res_log.size()) check("basic_res", 64'(res_log[b_r+i]), 64'(6 + 2*i));
    check("basic_nrd",     64'(rd_total - b_rd), 64'd4);
    check("basic_notbusy", 64'(busy), 64'd0);
    check("basic_empty",   64'(res_valid), 64'd0);

    // Backpressure: range 0..7, every setting succeeds, consumer stalled
    all_pass  = 1'b1;
    res_ready = 1'b0;
    b_s = start_total; b_r = res_log.size(); b_rd = rd_total;
    start_job(SW'(0), SW'(7));
    repeat (100) @(negedge clk);
    check("bp_found",   64'(found_count), 64'd2);
    check("bp_disp",    64'(dispatched_count), 64'd6);
    check("bp_nstart",  64'(start_total - b_s), 64'd6);
    check("bp_nrd",     64'(rd_total - b_rd), 64'd2);
    check("bp_valid",   64'(res_valid), 64'd1);
    check("bp_head",    64'(res_data), 64'd0);
    check("bp_busy",    64'(busy), 64'd1);
    check("bp_holding", 64'(tester_success), 64'hF);
    repeat (30) @(negedge clk);
    check("bp_nstart_hold", 64'(start_total - b_s), 64'd6);
    check("bp_nrd_hold",    64'(rd_total - b_rd), 64'd2);
    res_ready = 1'b1;
    wait_done("bp_done", 800);
    check("bp_found_end", 64'(found_count), 64'd8);
    check("bp_disp_end",  64'(dispatched_count), 64'd8);
    m = '0; cnt = 0;
    for (int i = b_r; i < res_log.size(); i++) begin
      tmp = res_log[i];
      cnt++;
      if (tmp < SW'(8)) m[tmp[2:0]] = 1'b1;
    end
    check("bp_nres",   64'(cnt), 64'd8);
    check("bp_resset", 64'(m), 64'hFF);
    check("bp_empty",  64'(res_valid), 64'd0);

    // Stale success flush combined with an empty range (first > last)
    all_pass = 1'b0;
    @(negedge clk);
    preset_req = 1'b1;
    @(negedge clk);
    preset_req = 1'b0;
    check("stale_preset", 64'(tester_success), 64'hF);
    b_s = start_total; b_r = res_log.size();
    for (int k = 0; k < NT; k++) b_rdp[k] = rd_per[k];
    start_job(SW'(9), SW'(3));
    wait_done("empty_done", 200);
    check("empty_nstart", 64'(start_total - b_s), 64'd0);
    check("empty_disp",   64'(dispatched_count), 64'd0);
    check("stale_found",  64'(found_count), 64'd0);
    check("stale_valid",  64'(res_valid), 64'd0);
    check("stale_nres",   64'(res_log.size() - b_r), 64'd0);
    for (int k = 0; k < NT; k++)
      check("stale_rd_seen", 64'(rd_per[k] > b_rdp[k]), 64'd1);
    check("stale_cleared", 64'(tester_success), 64'd0);

    // Single all-ones setting: exactly one start, no wrap
    all_pass = 1'b1;
    b_s = start_log.size(); b_r = res_log.size();
    start_job(ones, ones);
    wait_done("edge_done", 300);
    check("edge_nstart", 64'(start_log.size() - b_s), 64'd1);
    if (start_log.size() > b_s) check("edge_start_set", 64'(start_log[b_s]), 64'(ones));
    check("edge_disp",  64'(dispatched_count), 64'd1);
    check("edge_found", 64'(found_count), 64'd1);
    check("edge_nres",  64'(res_log.size() - b_r), 64'd1);
    if (res_log.size() > b_r) check("edge_res", 64'(res_log[b_r]), 64'(ones));

    // Reset while four testers are running
    all_pass = 1'b0;
    start_job(SW'(20), SW'(40));
    repeat (10) @(negedge clk);
    check("mid_busy",    64'(busy), 64'd1);
    check("mid_running", 64'(tester_idle), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy",  64'(busy), 64'd0);
    check("mid_rst_disp",  64'(dispatched_count), 64'd0);
    check("mid_rst_found", 64'(found_count), 64'd0);
    check("mid_rst_start", 64'(tester_start), 64'd0);
    check("mid_rst_rd",    64'(tester_rd_en), 64'd0);
    check("mid_rst_done",  64'(done), 64'd0);
    rst = 1'b0;
    b_s = start_total; b_rd = rd_total;
    repeat (40) @(negedge clk);
    check("post_rst_nstart", 64'(start_total - b_s), 64'd0);
    check("post_rst_nrd",    64'(rd_total - b_rd), 64'd0);
    check("post_rst_busy",   64'(busy), 64'd0);
    check("post_rst_valid",  64'(res_valid), 64'd0);

    // Next job after the aborted one: range 0..5, even settings succeed
    b_r = res_log.size();
    start_job(SW'(0), SW'(5));
    wait_done("rejob_done", 800);
    check("rejob_disp",  64'(dispatched_count), 64'd6);
    check("rejob_found", 64'(found_count), 64'd3);
    m = '0; cnt = 0;
    for (int i = b_r; i < res_log.size(); i++) begin
      tmp = res_log[i];
      cnt++;
      if (tmp < SW'(8)) m[tmp[2:0]] = 1'b1;
    end
    check("rejob_nres",   64'(cnt), 64'd3);
    check("rejob_resset", 64'(m), 64'h15);

    check("start_onehot", 64'(onehot_viol), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
